id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/immediate width.
REQ-002 SHALL have parameter CTRL_W, default 12, packed control-bundle width; bit 0 = RegWre, bit 1 = MemRead.
REQ-003 SHALL have port Clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports id_valid (in, 1, ID holds a real instruction), id_ctrl (in, CTRL_W), id_rs/id_rt/id_rd (in, 5 each), id_rdata1/id_rdata2 (in, DATA_W, register-file read data), id_imm (in, DATA_W).
REQ-006 SHALL have ports wb_we (in, 1), wb_waddr (in, 5), wb_wdata (in, DATA_W), mirroring the register-file write port.
REQ-007 SHALL have port flush  input  1  branch/jump squash of the ID instruction.
REQ-008 SHALL have outputs ex_valid, ex_ctrl, ex_rs, ex_rt, ex_rd, ex_a, ex_b, ex_imm (registered copies), plus stall (out, 1, combinational load-use hold request to PC and IF/ID).

Function
REQ-009 SHALL raise stall when ex_valid=1, ex_ctrl[1]=1, ex_rt!=0, id_valid=1 and (ex_rt==id_rs or ex_rt==id_rt).
REQ-010 SHALL, when stall=1 or flush=1 at an edge, load a bubble: ex_valid=0, ex_ctrl=0; ex_rs/rt/rd/a/b/imm don't-care but SHALL be zeroed.
REQ-011 SHALL otherwise capture all id_* fields at the edge: ex_valid<=id_valid, ex_ctrl<=(id_valid ? id_ctrl : 0).
REQ-012 SHALL apply flush priority over stall; both yield the identical bubble.
REQ-013 SHALL have latency exactly one cycle from id_* to ex_*; no other buffering.
REQ-014 SHALL gate outputs so ex_ctrl[0]=0 whenever ex_valid=0 (bubble never writes).
REQ-015 SHALL (bypass enabled) capture ex_a<=wb_wdata when wb_we=1, wb_waddr!=0 and wb_waddr==id_rs; likewise ex_b for id_rt; both may bypass in the same cycle.
REQ-016 SHALL never bypass for register 0; ex_a/ex_b SHALL equal id_rdata for rs/rt=0.
REQ-017 SHALL keep stall purely combinational from ex_* registers and id_* inputs (no self-loop through stall).

Reset
REQ-018 SHALL, when Reset=0 at an edge, clear every ex_* output to 0, overriding stall, flush and bypass.
REQ-019 SHALL drive stall=0 during and the cycle after reset (ex_valid=0).
REQ-020 SHALL treat reset mid-stall as discarding the stalled load; no recovery state retained.

Configuration
REQ-021 SHALL compile WB-to-ID bypass (REQ-015) only when macro ID_EX_WB_BYPASS_EN is defined.
REQ-022 SHALL, without ID_EX_WB_BYPASS_EN, capture id_rdata1/id_rdata2 unmodified; register file must then provide write-before-read.

Structure
REQ-023 SHALL place CTRL_W, control-bit indices (CTRL_REGWRE=0, CTRL_MEMREAD=1) and a bubble-constant in shared package cpu_pkg.
REQ-024 SHALL implement the hazard comparison as sub-module load_use_detect; remainder is flat.

Verification
REQ-025 Reset=0 one edge with all inputs 0xFFFF_FFFF -> all ex_* =0, stall=0.
REQ-026 ID lw-independent add rs=1,rt=2, rdata 5/7, no WB -> next cycle ex_a=5, ex_b=7, ex_valid=1.
REQ-027 EX lw rt=8 (ctrl[1]=1) + ID add rs=8 -> stall=1; next edge bubble (ex_valid=0, ex_ctrl=0); ID re-presented -> captured following cycle.
REQ-028 wb_we=1, wb_waddr=3, wb_wdata=0xDEAD_BEEF, id_rs=3, id_rt=3, rdata=0 -> ex_a=ex_b=0xDEAD_BEEF (macro on); =0 (macro off).
REQ-029 wb_we=1, wb_waddr=0, wb_wdata=0x1234, id_rs=0 -> ex_a=id_rdata1 (0).
REQ-030 flush=1 and stall=1 same cycle, then Reset=0 during stall -> bubble, then all-zero, stall=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: control-bundle layout, bubble constant and
// the register-match helper used by the ID/EX hazard logic.
package cpu_pkg;

   localparam int unsigned CTRL_W       = 12;
   localparam int unsigned CTRL_REGWRE  = 0;
   localparam int unsigned CTRL_MEMREAD = 1;
   localparam int unsigned REG_ADDR_W   = 5;

   localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   // r0 is hard-wired to zero, so it never creates a dependency.
   function automatic logic reg_match(input reg_addr_t a, input reg_addr_t b);
      return (a != '0) && (a == b);
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds the
// instruction currently in ID.
module load_use_detect
   import cpu_pkg::*;
(
   input  logic      ex_valid_i,
   input  logic      ex_memread_i,
   input  reg_addr_t ex_rt_i,
   input  logic      id_valid_i,
   input  reg_addr_t id_rs_i,
   input  reg_addr_t id_rt_i,
   output logic      stall_o
);

   assign stall_o = ex_valid_i & ex_memread_i & id_valid_i &
                    (reg_match(ex_rt_i, id_rs_i) | reg_match(ex_rt_i, id_rt_i));

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use stall and flush bubbles.
// Define ID_EX_WB_BYPASS_EN to forward the WB write port into ex_a/ex_b.
module id_ex_reg #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = cpu_pkg::CTRL_W
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              id_valid,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   input  logic [DATA_W-1:0] id_rdata1,
   input  logic [DATA_W-1:0] id_rdata2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              wb_we,
   input  logic [4:0]        wb_waddr,
   input  logic [DATA_W-1:0] wb_wdata,
   input  logic              flush,
   output logic              ex_valid,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [DATA_W-1:0] ex_imm,
   output logic              stall
);

   logic              valid_q, valid_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
   logic [DATA_W-1:0] a_fwd, b_fwd;
   logic              hazard;

   load_use_detect u_load_use_detect (
      .ex_valid_i   (valid_q),
      .ex_memread_i (ctrl_q[cpu_pkg::CTRL_MEMREAD]),
      .ex_rt_i      (rt_q),
      .id_valid_i   (id_valid),
      .id_rs_i      (id_rs),
      .id_rt_i      (id_rt),
      .stall_o      (hazard)
   );

   // Held low while in reset so PC/IF-ID never see a stale hold request.
   assign stall = hazard & Reset;

   always_comb begin
      a_fwd = id_rdata1;
      b_fwd = id_rdata2;
`ifdef ID_EX_WB_BYPASS_EN
      if (wb_we && cpu_pkg::reg_match(wb_waddr, id_rs)) a_fwd = wb_wdata;
      if (wb_we && cpu_pkg::reg_match(wb_waddr, id_rt)) b_fwd = wb_wdata;
`endif
   end

`ifndef ID_EX_WB_BYPASS_EN
   logic unused_wb;
   assign unused_wb = ^{wb_we, wb_waddr, wb_wdata};
`endif

   always_comb begin
      valid_d = id_valid;
      ctrl_d  = id_valid ? id_ctrl : CTRL_W'(cpu_pkg::CTRL_BUBBLE);
      rs_d    = id_rs;
      rt_d    = id_rt;
      rd_d    = id_rd;
      a_d     = a_fwd;
      b_d     = b_fwd;
      imm_d   = id_imm;
      if (flush || stall) begin
         valid_d = 1'b0;
         ctrl_d  = CTRL_W'(cpu_pkg::CTRL_BUBBLE);
         rs_d    = '0;
         rt_d    = '0;
         rd_d    = '0;
         a_d     = '0;
         b_d     = '0;
         imm_d   = '0;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         imm_q   <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         rd_q    <= rd_d;
         a_q     <= a_d;
         b_q     <= b_d;
         imm_q   <= imm_d;
      end
   end

   assign ex_valid = valid_q;
   assign ex_ctrl  = valid_q ? ctrl_q : CTRL_W'(cpu_pkg::CTRL_BUBBLE);
   assign ex_rs    = rs_q;
   assign ex_rt    = rt_q;
   assign ex_rd    = rd_q;
   assign ex_a     = a_q;
   assign ex_b     = b_q;
   assign ex_imm   = imm_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: driver pushes hand-computed EX contents,
// monitor pops and compares one entry per rising edge.
module tb_id_ex_reg;

   typedef struct packed {
      logic        v;
      logic [11:0] ctrl;
      logic [4:0]  rs, rt, rd;
      logic [31:0] a, b, imm;
   } ex_t;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        id_valid, wb_we, flush;
   logic [11:0] id_ctrl;
   logic [4:0]  id_rs, id_rt, id_rd, wb_waddr;
   logic [31:0] id_rdata1, id_rdata2, id_imm, wb_wdata;
   logic        ex_valid, stall;
   logic [11:0] ex_ctrl;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic [31:0] ex_a, ex_b, ex_imm;

   ex_t   exp_q[$];
   string name_q[$];
   int    n_vec = 0;
   int    n_err = 0;

`ifdef ID_EX_WB_BYPASS_EN
   localparam bit BP = 1'b1;
`else
   localparam bit BP = 1'b0;
`endif

   id_ex_reg dut (
      .Clk(Clk), .Reset(Reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rdata1(id_rdata1),
      .id_rdata2(id_rdata2), .id_imm(id_imm), .wb_we(wb_we), .wb_waddr(wb_waddr),
      .wb_wdata(wb_wdata), .flush(flush), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b),
      .ex_imm(ex_imm), .stall(stall)
   );

   always #5 Clk = ~Clk;

   task automatic drive(input logic v, input logic [11:0] c, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] imm, input logic fl);
      id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd;
      id_rdata1 = r1; id_rdata2 = r2; id_imm = imm; flush = fl;
   endtask

   task automatic wb(input logic we, input logic [4:0] addr, input logic [31:0] data);
      wb_we = we; wb_waddr = addr; wb_wdata = data;
   endtask

   task automatic push(input string nm, input logic v, input logic [11:0] c,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
      ex_t e;
      e.v = v; e.ctrl = c; e.rs = rs; e.rt = rt; e.rd = rd; e.a = a; e.b = b; e.imm = imm;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic push_bubble(input string nm);
      push(nm, 1'b0, 12'h000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic chk_stall(input string nm, input logic exp);
      #1;
      n_vec++;
      if (stall !== exp) begin
         n_err++;
         $display("FAIL %s: stall got %b want %b", nm, stall, exp);
      end
   endtask

   // Monitor: EX outputs are presented every cycle, so one entry per edge.
   initial begin
      ex_t   e;
      ex_t   got;
      string nm;
      forever begin
         @(posedge Clk);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            got = {ex_valid, ex_ctrl, ex_rs, ex_rt, ex_rd, ex_a, ex_b, ex_imm};
            n_vec++;
            if (got !== e) begin
               n_err++;
               $display("FAIL %s: got v=%b ctrl=%h rs=%0d rt=%0d rd=%0d a=%h b=%h imm=%h want v=%b ctrl=%h rs=%0d rt=%0d rd=%0d a=%h b=%h imm=%h",
                        nm, got.v, got.ctrl, got.rs, got.rt, got.rd, got.a, got.b, got.imm,
                        e.v, e.ctrl, e.rs, e.rt, e.rd, e.a, e.b, e.imm);
            end
         end
      end
   end

   initial begin
      Reset = 1'b0;
      drive(1'b0, 12'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
      wb(1'b0, 5'd0, 32'h0);

      @(negedge Clk);
      Reset = 1'b0;
      drive(1'b1, 12'hFFF, 5'd31, 5'd31, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      wb(1'b1, 5'd31, 32'hFFFF_FFFF);
      chk_stall("reset_stall", 1'b0);
      push_bubble("reset_all_ones");

      @(negedge Clk);
      Reset = 1'b1;
      wb(1'b0, 5'd0, 32'h0);
      drive(1'b1, 12'h001, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h10, 1'b0);
      chk_stall("post_reset_stall", 1'b0);
      push("add_basic", 1'b1, 12'h001, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h10);

      @(negedge Clk);
      drive(1'b1, 12'h003, 5'd4, 5'd8, 5'd0, 32'h100, 32'h55, 32'h4, 1'b0);
      chk_stall("lw8_stall", 1'b0);
      push("lw8", 1'b1, 12'h003, 5'd4, 5'd8, 5'd0, 32'h100, 32'h55, 32'h4);

      @(negedge Clk);
      drive(1'b1, 12'h001, 5'd8, 5'd9, 5'd10, 32'd11, 32'd22, 32'h0, 1'b0);
      chk_stall("loaduse_rs_stall", 1'b1);
      push_bubble("loaduse_rs_bubble");

      @(negedge Clk);
      chk_stall("represent_stall", 1'b0);
      push("represent_add", 1'b1, 12'h001, 5'd8, 5'd9, 5'd10, 32'd11, 32'd22, 32'h0);

      @(negedge Clk);
      drive(1'b0, 12'hFFF, 5'd8, 5'd5, 5'd6, 32'd1, 32'd2, 32'd3, 1'b0);
      chk_stall("invalid_id_stall", 1'b0);
      push("invalid_id", 1'b0, 12'h000, 5'd8, 5'd5, 5'd6, 32'd1, 32'd2, 32'd3);

      @(negedge Clk);
      drive(1'b1, 12'h003, 5'd0, 5'd5, 5'd0, 32'h0, 32'h0, 32'h8, 1'b0);
      chk_stall("lw5_stall", 1'b0);
      push("lw5", 1'b1, 12'h003, 5'd0, 5'd5, 5'd0, 32'h0, 32'h0, 32'h8);

      @(negedge Clk);
      drive(1'b1, 12'h001, 5'd5, 5'd1, 5'd2, 32'h33, 32'h44, 32'h0, 1'b1);
      chk_stall("flush_and_stall", 1'b1);
      push_bubble("flush_and_stall_bubble");

      @(negedge Clk);
      drive(1'b1, 12'h003, 5'd0, 5'd6, 5'd0, 32'h0, 32'h0, 32'hC, 1'b0);
      chk_stall("lw6_stall", 1'b0);
      push("lw6", 1'b1, 12'h003, 5'd0, 5'd6, 5'd0, 32'h0, 32'h0, 32'hC);

      @(negedge Clk);
      drive(1'b1, 12'h001, 5'd2, 5'd6, 5'd7, 32'h70, 32'h60, 32'h0, 1'b0);
      chk_stall("loaduse_rt_stall", 1'b1);
      Reset = 1'b0;
      chk_stall("reset_mid_stall", 1'b0);
      push_bubble("reset_mid_stall_clear");

      @(negedge Clk);
      Reset = 1'b1;
      chk_stall("after_reset_stall", 1'b0);
      push("after_reset_add", 1'b1, 12'h001, 5'd2, 5'd6, 5'd7, 32'h70, 32'h60, 32'h0);

      @(negedge Clk);
      wb(1'b1, 5'd3, 32'hDEAD_BEEF);
      drive(1'b1, 12'h001, 5'd3, 5'd3, 5'd4, 32'h0, 32'h0, 32'h0, 1'b0);
      chk_stall("bypass_both_stall", 1'b0);
      push("bypass_both", 1'b1, 12'h001, 5'd3, 5'd3, 5'd4,
           BP ? 32'hDEAD_BEEF : 32'h0, BP ? 32'hDEAD_BEEF : 32'h0, 32'h0);

      @(negedge Clk);
      wb(1'b1, 5'd0, 32'h1234);
      drive(1'b1, 12'h001, 5'd0, 5'd0, 5'd5, 32'h0, 32'h77, 32'h0, 1'b0);
      push("bypass_r0", 1'b1, 12'h001, 5'd0, 5'd0, 5'd5, 32'h0, 32'h77, 32'h0);

      @(negedge Clk);
      wb(1'b1, 5'd7, 32'hCAFE);
      drive(1'b1, 12'h001, 5'd2, 5'd7, 5'd1, 32'hA, 32'hB, 32'h0, 1'b0);
      push("bypass_rt_only", 1'b1, 12'h001, 5'd2, 5'd7, 5'd1, 32'hA,
           BP ? 32'hCAFE : 32'hB, 32'h0);

      @(negedge Clk);
      wb(1'b0, 5'd2, 32'hBAD);
      drive(1'b1, 12'h001, 5'd2, 5'd2, 5'd1, 32'h21, 32'h22, 32'h0, 1'b0);
      push("wb_we_low", 1'b1, 12'h001, 5'd2, 5'd2, 5'd1, 32'h21, 32'h22, 32'h0);

      @(negedge Clk);
      wb(1'b0, 5'd0, 32'h0);
      drive(1'b1, 12'h003, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
      push("lw_r0", 1'b1, 12'h003, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);

      @(negedge Clk);
      drive(1'b1, 12'h001, 5'd0, 5'd0, 5'd3, 32'h5, 32'h6, 32'h0, 1'b0);
      chk_stall("lw_r0_no_stall", 1'b0);
      push("after_lw_r0", 1'b1, 12'h001, 5'd0, 5'd0, 5'd3, 32'h5, 32'h6, 32'h0);

      @(negedge Clk);
      drive(1'b1, 12'h003, 5'd0, 5'd9, 5'd0, 32'h0, 32'h0, 32'h10, 1'b0);
      push("lw9", 1'b1, 12'h003, 5'd0, 5'd9, 5'd0, 32'h0, 32'h0, 32'h10);

      @(negedge Clk);
      drive(1'b1, 12'h001, 5'd1, 5'd9, 5'd2, 32'h1, 32'h2, 32'h0, 1'b0);
      chk_stall("loaduse_rt9_stall", 1'b1);
      push_bubble("loaduse_rt9_bubble");

      @(negedge Clk);
      drive(1'b1, 12'h001, 5'd1, 5'd9, 5'd2, 32'h1, 32'h2, 32'h0, 1'b1);
      chk_stall("flush_only_stall", 1'b0);
      push_bubble("flush_only_bubble");

      @(negedge Clk);
      drive(1'b0, 12'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
      push("idle", 1'b0, 12'h000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);

      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge Clk);
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
